// File: rtl/updown_match_counter.sv
// Two-button up/down counter with TARGET match level, entry pulse and limit flags.
// Define COUNT_DEBOUNCE_EN to insert a per-button debounce filter after each synchroniser.
module updown_match_counter #(
  parameter int WIDTH           = 4,
  parameter int TARGET          = 11,
  parameter int SATURATE        = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             clear,
  output logic [WIDTH-1:0] num,
  output logic             out,
  output logic             hit,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] TGT     = WIDTH'(TARGET);
  localparam logic             IDLE    = 1'b0;
  localparam logic             MATCH   = 1'b1;

  logic [1:0] btn;
  logic [1:0] press;

  assign btn = {B, A};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_reg;
      logic sync2_reg;
      logic prev_reg;
      logic level;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= btn[gi];
          sync2_reg <= sync1_reg;
        end
      end

`ifdef COUNT_DEBOUNCE_EN
      logic       filt_reg;
      logic [7:0] stable_reg;

      // Flip only on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          filt_reg   <= 1'b0;
          stable_reg <= 8'd0;
        end else if (sync2_reg != filt_reg) begin
          if (stable_reg == 8'(DEBOUNCE_CYCLES - 1)) begin
            filt_reg   <= sync2_reg;
            stable_reg <= 8'd0;
          end else begin
            stable_reg <= stable_reg + 8'd1;
          end
        end else begin
          stable_reg <= 8'd0;
        end
      end

      assign level = filt_reg;
`else
      assign level = sync2_reg;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_reg <= 1'b0;
        end else begin
          prev_reg <= level;
        end
      end

      assign press[gi] = level & ~prev_reg;
    end
  endgenerate

  logic             up;
  logic             dn;
  logic [WIDTH-1:0] num_next;
  logic             ovf_next;
  logic             unf_next;
  logic             state_reg;
  logic             state_next;
  logic             hit_next;
  logic             armed_reg;

  assign up = press[0];
  assign dn = press[1];

  always_comb begin
    num_next = num;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (clear) begin
      num_next = '0;
    end else if (up && dn) begin
      num_next = num;
    end else if (up) begin
      if (num == MAX_VAL) begin
        ovf_next = 1'b1;
        num_next = (SATURATE != 0) ? num : '0;
      end else begin
        num_next = num + WIDTH'(1);
      end
    end else if (dn) begin
      if (num == '0) begin
        unf_next = 1'b1;
        num_next = (SATURATE != 0) ? num : MAX_VAL;
      end else begin
        num_next = num - WIDTH'(1);
      end
    end
  end

  // armed_reg keeps the first post-reset entry (TARGET==0) from pulsing hit.
  always_comb begin
    state_next = (num_next == TGT) ? MATCH : IDLE;
    hit_next   = (state_next == MATCH) && (state_reg == IDLE) && armed_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num       <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      hit       <= 1'b0;
      state_reg <= IDLE;
      armed_reg <= 1'b0;
    end else begin
      num       <= num_next;
      ovf       <= ovf_next;
      unf       <= unf_next;
      hit       <= hit_next;
      state_reg <= state_next;
      armed_reg <= 1'b1;
    end
  end

  assign out = (state_reg == MATCH);

endmodule

// File: tb/tb_updown_match_counter.sv
// Randomised bench for updown_match_counter: wrap and saturate instances share stimulus
// and are checked against a step-level arithmetic model.
module tb_updown_match_counter;

  localparam int W  = 4;
  localparam int T  = 11;
  localparam int MX = (1 << W) - 1;
`ifdef COUNT_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 3 + DB;

  localparam int OP_UP   = 0;
  localparam int OP_DN   = 1;
  localparam int OP_BOTH = 2;
  localparam int OP_CLR  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a     = 1'b0;
  logic b     = 1'b0;
  logic clr   = 1'b0;

  logic [1:0][W-1:0] num_v;
  logic [1:0]        out_v;
  logic [1:0]        hit_v;
  logic [1:0]        ovf_v;
  logic [1:0]        unf_v;

  int tests = 0;
  int fails = 0;

  int m_num [2];
  bit e_hit [2];
  bit e_ovf [2];
  bit e_unf [2];

  always #5 clk = ~clk;

  updown_match_counter #(.WIDTH(W), .TARGET(T), .SATURATE(0), .DEBOUNCE_CYCLES(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .clear(clr),
    .num(num_v[0]), .out(out_v[0]), .hit(hit_v[0]), .ovf(ovf_v[0]), .unf(unf_v[0])
  );

  updown_match_counter #(.WIDTH(W), .TARGET(T), .SATURATE(1), .DEBOUNCE_CYCLES(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .clear(clr),
    .num(num_v[1]), .out(out_v[1]), .hit(hit_v[1]), .ovf(ovf_v[1]), .unf(unf_v[1])
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%s]: observed %0d expected %0d", tag, (idx == 0) ? "wrap" : "sat", obs, exp);
    end
  endtask

  // Step-level model: the counter moves by whole presses, with wrap or clamp at the ends.
  function automatic void model_op(input int op);
    for (int i = 0; i < 2; i++) begin
      int old_v;
      int new_v;
      old_v = m_num[i];
      new_v = old_v;
      e_ovf[i] = 1'b0;
      e_unf[i] = 1'b0;
      case (op)
        OP_UP: begin
          e_ovf[i] = (old_v + 1 > MX);
          new_v = (i == 1) ? ((old_v + 1 > MX) ? MX : old_v + 1) : (old_v + 1) % (MX + 1);
        end
        OP_DN: begin
          e_unf[i] = (old_v - 1 < 0);
          new_v = (i == 1) ? ((old_v - 1 < 0) ? 0 : old_v - 1) : (old_v - 1 + MX + 1) % (MX + 1);
        end
        OP_CLR:  new_v = 0;
        default: new_v = old_v;
      endcase
      e_hit[i] = (new_v == T) && (old_v != T);
      m_num[i] = new_v;
    end
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_num"}, i, 32'(num_v[i]), 32'(m_num[i]));
      chk({tag, "_out"}, i, 32'(out_v[i]), 32'(m_num[i] == T));
      chk({tag, "_hit"}, i, 32'(hit_v[i]), 32'(e_hit[i]));
      chk({tag, "_ovf"}, i, 32'(ovf_v[i]), 32'(e_ovf[i]));
      chk({tag, "_unf"}, i, 32'(unf_v[i]), 32'(e_unf[i]));
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_num"}, i, 32'(num_v[i]), 32'(m_num[i]));
      chk({tag, "_hit"}, i, 32'(hit_v[i]), 32'd0);
      chk({tag, "_ovf"}, i, 32'(ovf_v[i]), 32'd0);
      chk({tag, "_unf"}, i, 32'(unf_v[i]), 32'd0);
    end
  endtask

  task automatic step(input int op, input int hold_extra);
    @(negedge clk);
    if (op == OP_CLR) begin
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_op(op);
      check_all("clear");
      $display("[TB] clear -> wrap=%0d sat=%0d", m_num[0], m_num[1]);
      return;
    end
    a = (op == OP_UP) || (op == OP_BOTH);
    b = (op == OP_DN) || (op == OP_BOTH);
    repeat (LAT - 1) @(negedge clk);
    check_quiet("pre");
    @(negedge clk);
    model_op(op);
    check_all("step");
    $display("[TB] op=%0d -> wrap=%0d sat=%0d hit=%0d/%0d", op, m_num[0], m_num[1], e_hit[0], e_hit[1]);
    @(negedge clk);
    check_quiet("after");
    for (int k = 0; k < hold_extra; k++) begin
      @(negedge clk);
      if (k == hold_extra - 1) check_quiet("held");
    end
    a = 1'b0;
    b = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_num", i, 32'(num_v[i]), 32'd0);
      chk("rst_out", i, 32'(out_v[i]), 32'd0);
      chk("rst_hit", i, 32'(hit_v[i]), 32'd0);
      chk("rst_ovf", i, 32'(ovf_v[i]), 32'd0);
      chk("rst_unf", i, 32'(unf_v[i]), 32'd0);
    end
    $display("[TB] async reset asserted mid-count");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_num[i] = 0;
      e_hit[i] = 1'b0;
      e_ovf[i] = 1'b0;
      e_unf[i] = 1'b0;
    end
    @(negedge clk);
    check_all("post_rst");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_num[i] = 0;
      e_hit[i] = 1'b0;
      e_ovf[i] = 1'b0;
      e_unf[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset_rel");
    $display("[TB] reset released");

    for (int n = 0; n < 11; n++) step(OP_UP, 0);
    step(OP_DN, 0);
    step(OP_UP, 20 - LAT - 1);
    step(OP_BOTH, 0);
    step(OP_CLR, 0);
    step(OP_DN, 0);
    for (int n = 0; n < 16; n++) step(OP_UP, 0);

`ifdef COUNT_DEBOUNCE_EN
    @(negedge clk);
    a = 1'b1;
    repeat (3) @(negedge clk);
    a = 1'b0;
    repeat (10) @(negedge clk);
    check_quiet("glitch");
    $display("[TB] 3-cycle glitch on A -> wrap=%0d sat=%0d", m_num[0], m_num[1]);
`endif

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (n == 20) mid_reset();
      if (r < 4)       step(OP_UP, int'($urandom_range(0, 3)));
      else if (r < 8)  step(OP_DN, int'($urandom_range(0, 3)));
      else if (r == 8) step(OP_BOTH, 0);
      else             step(OP_CLR, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
